sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25, meaning the SDRAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, meaning the SDRAM data width.
REQ-003 SHALL have parameter RR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to port 0.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; these are the first two ports below.
REQ-005 clk  input  1  sole clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 c0_addr  input  ADDR_W  port 0 (MPEG memory shim) byte address.
REQ-008 c0_rd / c0_wr  input  1 each  port 0 one-cycle read / write strobes.
REQ-009 c0_din  input  DATA_W  port 0 write data.
REQ-010 c0_dout  output  DATA_W  port 0 read data, valid when c0_ack is high.
REQ-011 c0_ack  output  1  port 0 one-cycle completion pulse.
REQ-012 c0_busy  output  1  port 0 not ready for a new strobe.
REQ-013 c1_addr, c1_rd, c1_wr, c1_din, c1_dout, c1_ack, c1_busy: same as REQ-007..012, for port 1 (HPS bitstream loader).
REQ-014 m_addr  output  ADDR_W  address to the SDRAM controller.
REQ-015 m_rd / m_wr  output  1 each  one-cycle strobes to the controller.
REQ-016 m_din  output  DATA_W  write data to the controller.
REQ-017 m_dout  input  DATA_W  controller read data, valid with m_ack.
REQ-018 m_ack  input  1  controller one-cycle completion pulse.
REQ-019 m_busy  input  1  controller not accepting strobes.

Function
REQ-020 Each port SHALL own a one-entry request latch holding addr, din and op (RD/WR) plus a pending flag.
REQ-021 A strobe on port N with its latch empty SHALL be captured at that clock edge and set pending.
REQ-022 If cN_rd and cN_wr are both high in the same cycle, the request SHALL be captured as a write.
REQ-023 A strobe arriving while port N is pending or in flight SHALL be ignored, with no state change.
REQ-024 cN_busy SHALL be a registered output, high whenever port N is pending or in flight.
REQ-025 The arbiter SHALL use state machine states IDLE and WAIT.
REQ-026 In IDLE, with at least one port pending and m_busy low, the arbiter SHALL select a port.
REQ-027 When it selects a port, it SHALL register m_addr/m_din from that latch, pulse m_rd or m_wr for exactly one cycle, record the grant, and enter WAIT.
REQ-028 In IDLE with m_busy high, no strobe SHALL be issued; pending requests SHALL be held.
REQ-029 Port selection: only one pending -> that port; both pending with RR=1 -> the port not granted last; both pending with RR=0 -> port 0.
REQ-030 last_grant SHALL reset to 1, so port 0 wins the first tie.
REQ-031 In WAIT, on m_ack, the arbiter SHALL register cN_dout <= m_dout and pulse cN_ack for one cycle on the granted port only.
REQ-032 On that same edge, the arbiter SHALL clear that port's pending and in-flight status, update last_grant, and return to IDLE.
REQ-033 Latency: m_ack at cycle t -> cN_ack and cN_dout at cycle t+1, with cN_busy low at t+1.
REQ-034 For writes, cN_dout SHALL be updated with m_dout as well (don't-care for the client); cN_ack SHALL still pulse.
REQ-035 The earliest re-issue after an ack SHALL be the cycle after the return to IDLE; there SHALL be no back-to-back m strobes without an intervening m_ack.
REQ-036 m_ack received in IDLE SHALL be ignored.
REQ-037 The non-granted port's latch SHALL remain untouched in WAIT and SHALL accept a strobe if empty.
REQ-038 A strobe on port N in the same cycle that cN_ack is high SHALL be accepted, because busy was already low.
REQ-039 cN_ack SHALL never assert on both ports in the same cycle.
REQ-040 There SHALL be at most one controller request outstanding.

Reset
REQ-041 On rst high, asynchronously: state=IDLE, both latches empty, last_grant=1, all strobes/acks/busy outputs = 0, and all addr/data outputs = 0.
REQ-042 A reset while in WAIT SHALL abandon the in-flight request with no cN_ack; a late m_ack after reset SHALL be ignored per REQ-036.

Verification
REQ-043 c0_rd addr 0x000010, m_busy=0, m_ack 5 cycles after m_rd with m_dout=0xBEEF -> exactly one m_rd with m_addr=0x000010; one cycle after m_ack, c0_ack=1 and c0_dout=0xBEEF; c0_busy low.
REQ-044 c0_wr 0x100/0x1234 and c1_wr 0x200/0x5678 in the same cycle, repeated 4 times, RR=1 -> grants alternate 0,1,0,1 with m_din matching each port; rerun with RR=0 -> port 0 is served before any port 1 request pending since the same cycle.
REQ-045 m_busy held high 20 cycles with c1_rd pending -> no m strobe; m_rd issues in the first IDLE cycle after m_busy falls.
REQ-046 c0_rd and c0_wr high together -> m_wr issued, not m_rd; a second c0_rd strobe while c0_busy is high -> ignored, with one m strobe only.
REQ-047 rst pulsed while in WAIT on port 1, then m_ack -> no c1_ack, all outputs 0, and the next c0_rd is served normally.
REQ-048 c0_rd issued on the cycle c0_ack pulses -> accepted; a new m_rd follows without loss.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Two-client arbiter in front of a single-request SDRAM controller.
// Each client port owns a one-entry request latch; the arbiter forwards one
// latched request at a time to the controller and routes the completion
// (ack + read data) back to the port that was granted.
//
// Ports
//   clk, rst                 : sole clock, asynchronous active-high reset
//   c0_* (MPEG memory shim)  : addr/rd/wr/din in, dout/ack/busy out
//   c1_* (HPS bitstream load): same as c0_*
//   m_addr, m_rd, m_wr, m_din: registered request to the SDRAM controller
//   m_dout, m_ack, m_busy    : controller read data, completion, not-ready
// Parameters
//   ADDR_W : byte-address width
//   DATA_W : data width
//   RR     : 1 = round-robin on ties, 0 = port 0 always wins ties
module sdram_arbiter #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 16,
  parameter int RR     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic              c0_rd,
  input  logic              c0_wr,
  input  logic [DATA_W-1:0] c0_din,
  output logic [DATA_W-1:0] c0_dout,
  output logic              c0_ack,
  output logic              c0_busy,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic              c1_rd,
  input  logic              c1_wr,
  input  logic [DATA_W-1:0] c1_din,
  output logic [DATA_W-1:0] c1_dout,
  output logic              c1_ack,
  output logic              c1_busy,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_ack,
  input  logic              m_busy
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t                 state_q;
  // vld_q[n] covers both "pending" and "in flight": the latch is occupied
  // from capture until the controller acks it, which is exactly cN_busy.
  logic [1:0]             vld_q;
  logic [1:0]             wr_q;
  logic [1:0][ADDR_W-1:0] addr_q;
  logic [1:0][DATA_W-1:0] din_q;
  logic [1:0][DATA_W-1:0] dout_q;
  logic [1:0]             ack_q;
  logic                   grant_q;
  logic                   last_q;
  logic [ADDR_W-1:0]      m_addr_q;
  logic [DATA_W-1:0]      m_din_q;
  logic                   m_rd_q;
  logic                   m_wr_q;

  logic [1:0]             stb_s;
  logic [1:0]             stb_wr_s;
  logic [1:0][ADDR_W-1:0] in_addr_s;
  logic [1:0][DATA_W-1:0] in_din_s;
  logic                   sel_s;

  // A strobe with both rd and wr set is taken as a write.
  assign stb_s     = {c1_rd | c1_wr, c0_rd | c0_wr};
  assign stb_wr_s  = {c1_wr, c0_wr};
  assign in_addr_s = {c1_addr, c0_addr};
  assign in_din_s  = {c1_din, c0_din};

  // Port selection; only meaningful in IDLE, where every valid latch is pending.
  always_comb begin
    sel_s = 1'b0;
    if (vld_q == 2'b11) begin
      if (RR != 0) begin
        sel_s = ~last_q;
      end else begin
        sel_s = 1'b0;
      end
    end else if (vld_q[1]) begin
      sel_s = 1'b1;
    end else begin
      sel_s = 1'b0;
    end
  end

  // Request latches, arbitration FSM and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      vld_q    <= 2'b00;
      wr_q     <= 2'b00;
      addr_q   <= '0;
      din_q    <= '0;
      dout_q   <= '0;
      ack_q    <= 2'b00;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      m_addr_q <= '0;
      m_din_q  <= '0;
      m_rd_q   <= 1'b0;
      m_wr_q   <= 1'b0;
    end else begin
      m_rd_q <= 1'b0;
      m_wr_q <= 1'b0;
      ack_q  <= 2'b00;
      // An occupied latch ignores new strobes entirely.
      for (int n = 0; n < 2; n++) begin
        if (stb_s[n] && !vld_q[n]) begin
          vld_q[n]  <= 1'b1;
          wr_q[n]   <= stb_wr_s[n];
          addr_q[n] <= in_addr_s[n];
          din_q[n]  <= in_din_s[n];
        end
      end
      case (state_q)
        IDLE: begin
          if ((vld_q != 2'b00) && !m_busy) begin
            grant_q  <= sel_s;
            m_addr_q <= addr_q[sel_s];
            m_din_q  <= din_q[sel_s];
            m_rd_q   <= ~wr_q[sel_s];
            m_wr_q   <= wr_q[sel_s];
            state_q  <= WAIT;
          end
        end
        WAIT: begin
          // Write acks also carry m_dout back; the client ignores it.
          if (m_ack) begin
            dout_q[grant_q] <= m_dout;
            ack_q[grant_q]  <= 1'b1;
            vld_q[grant_q]  <= 1'b0;
            last_q          <= grant_q;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c0_dout = dout_q[0];
  assign c1_dout = dout_q[1];
  assign c0_ack  = ack_q[0];
  assign c1_ack  = ack_q[1];
  assign c0_busy = vld_q[0];
  assign c1_busy = vld_q[1];
  assign m_addr  = m_addr_q;
  assign m_din   = m_din_q;
  assign m_rd    = m_rd_q;
  assign m_wr    = m_wr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: instance 0 uses RR=1, instance 1 uses RR=0; both
// share client-side stimulus, each has its own controller model (fixed
// 5-cycle ack latency, read data = addr[15:0] ^ 16'hBEFF).
module tb_sdram_arbiter;

  typedef struct packed {
    logic        wr;
    logic [24:0] addr;
    logic [15:0] din;
  } mtx_t;

  typedef struct packed {
    logic        port;
    logic [15:0] dout;
  } atx_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [24:0]       c0_addr = '0, c1_addr = '0;
  logic              c0_rd = 1'b0, c0_wr = 1'b0, c1_rd = 1'b0, c1_wr = 1'b0;
  logic [15:0]       c0_din = '0, c1_din = '0;
  logic              m_busy = 1'b0;
  logic [1:0]        m_rd, m_wr, c0_ack, c1_ack, c0_busy, c1_busy;
  logic [1:0]        m_ack = 2'b00;
  logic [1:0][24:0]  m_addr;
  logic [1:0][15:0]  m_din, c0_dout, c1_dout;
  logic [1:0][15:0]  m_dout = '0;

  int   tests = 0;
  int   fails = 0;
  mtx_t qm[2][$];
  atx_t qa[2][$];
  int   nstrobe[2] = '{0, 0};
  int   nack[2]    = '{0, 0};
  int   cnt[2]     = '{0, 0};
  logic [24:0] lat_addr[2];
  logic [1:0]  m_ack_prev = 2'b00;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_arbiter #(.ADDR_W(25), .DATA_W(16), .RR((g == 0) ? 1 : 0)) dut (
      .clk(clk), .rst(rst),
      .c0_addr(c0_addr), .c0_rd(c0_rd), .c0_wr(c0_wr), .c0_din(c0_din),
      .c0_dout(c0_dout[g]), .c0_ack(c0_ack[g]), .c0_busy(c0_busy[g]),
      .c1_addr(c1_addr), .c1_rd(c1_rd), .c1_wr(c1_wr), .c1_din(c1_din),
      .c1_dout(c1_dout[g]), .c1_ack(c1_ack[g]), .c1_busy(c1_busy[g]),
      .m_addr(m_addr[g]), .m_rd(m_rd[g]), .m_wr(m_wr[g]), .m_din(m_din[g]),
      .m_dout(m_dout[g]), .m_ack(m_ack[g]), .m_busy(m_busy)
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic em(input int d, input logic wr, input logic [24:0] addr, input logic [15:0] din);
    mtx_t e;
    e.wr = wr; e.addr = addr; e.din = din;
    qm[d].push_back(e);
  endtask

  task automatic ea(input int d, input logic port, input logic [24:0] addr);
    atx_t a;
    a.port = port; a.dout = addr[15:0] ^ 16'hBEFF;
    qa[d].push_back(a);
  endtask

  task automatic strobe(input int p, input logic rd, input logic wr, input logic [24:0] addr, input logic [15:0] din);
    if (p == 0) begin
      c0_rd = rd; c0_wr = wr; c0_addr = addr; c0_din = din;
    end else begin
      c1_rd = rd; c1_wr = wr; c1_addr = addr; c1_din = din;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    c0_rd = 1'b0; c0_wr = 1'b0; c1_rd = 1'b0; c1_wr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ctl[%0d]", d), {c0_busy[d], c1_busy[d], c0_ack[d], c1_ack[d], m_rd[d], m_wr[d]}, 32'd0);
      chk($sformatf("rst_m_addr[%0d]", d), m_addr[d], 32'd0);
      chk($sformatf("rst_m_din[%0d]", d), m_din[d], 32'd0);
      chk($sformatf("rst_dout[%0d]", d), {c0_dout[d], c1_dout[d]}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (qm[0].size() == 0) && (qm[1].size() == 0) && (qa[0].size() == 0) &&
             (qa[1].size() == 0) && (c0_busy == 2'b00) && (c1_busy == 2'b00);
    end
    chk("idle_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_c0_ack(input string tag);
    for (int i = 0; i < 60 && c0_ack[0] !== 1'b1; i++) @(negedge clk);
    chk(tag, 32'(c0_ack[0]), 32'd1);
  endtask

  // Controller model: one outstanding request, ack 5 cycles after the strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      m_ack[d] <= 1'b0;
      if (cnt[d] != 0) begin
        cnt[d] <= cnt[d] - 1;
        if (cnt[d] == 1) begin
          m_ack[d]  <= 1'b1;
          m_dout[d] <= lat_addr[d][15:0] ^ 16'hBEFF;
        end
      end
      if (!rst && (m_rd[d] || m_wr[d])) begin
        chk($sformatf("single_outstanding[%0d]", d), 32'(cnt[d] == 0), 32'd1);
        cnt[d]      <= 5;
        lat_addr[d] <= m_addr[d];
      end
    end
  end

  // Scoreboard monitor: compares every controller strobe and every client ack.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      mtx_t e;
      atx_t a;
      if (!rst) begin
        if (m_rd[d] || m_wr[d]) begin
          nstrobe[d]++;
          chk($sformatf("m_single_op[%0d]", d), 32'(m_rd[d] & m_wr[d]), 32'd0);
          chk($sformatf("m_expected[%0d]", d), 32'(qm[d].size() != 0), 32'd1);
          if (qm[d].size() != 0) begin
            e = qm[d].pop_front();
            chk($sformatf("m_wr[%0d]", d), 32'(m_wr[d]), 32'(e.wr));
            chk($sformatf("m_addr[%0d]", d), 32'(m_addr[d]), 32'(e.addr));
            if (e.wr) chk($sformatf("m_din[%0d]", d), 32'(m_din[d]), 32'(e.din));
          end
        end
        if (c0_ack[d] || c1_ack[d]) begin
          nack[d]++;
          chk($sformatf("ack_one_port[%0d]", d), 32'(c0_ack[d] & c1_ack[d]), 32'd0);
          chk($sformatf("ack_after_m_ack[%0d]", d), 32'(m_ack_prev[d]), 32'd1);
          chk($sformatf("ack_expected[%0d]", d), 32'(qa[d].size() != 0), 32'd1);
          if (qa[d].size() != 0) begin
            a = qa[d].pop_front();
            chk($sformatf("ack_port[%0d]", d), 32'(c1_ack[d]), 32'(a.port));
            chk($sformatf("ack_dout[%0d]", d), 32'(a.port ? c1_dout[d] : c0_dout[d]), 32'(a.dout));
            chk($sformatf("ack_busy_low[%0d]", d), 32'(a.port ? c1_busy[d] : c0_busy[d]), 32'd0);
          end
        end
      end
      m_ack_prev[d] = m_ack[d];
    end
  end

  initial begin
    int nb0, nb1, na0;
    @(negedge clk);
    do_reset();

    // Single read on port 0, data 0xBEEF one cycle after m_ack.
    for (int d = 0; d < 2; d++) begin em(d, 1'b0, 25'h10, 16'h0); ea(d, 1'b0, 25'h10); end
    nb0 = nstrobe[0];
    strobe(0, 1'b1, 1'b0, 25'h10, 16'h0);
    tick();
    chk("t1_busy_high", 32'(c0_busy[0]), 32'd1);
    wait_c0_ack("t1_ack_seen");
    chk("t1_dout", 32'(c0_dout[0]), 32'h0000BEEF);
    chk("t1_busy_low", 32'(c0_busy[0]), 32'd0);
    wait_idle();
    chk("t1_one_strobe", 32'(nstrobe[0] - nb0), 32'd1);

    // Simultaneous writes on both ports, four times.
    do_reset();
    for (int r = 0; r < 4; r++) begin
      for (int d = 0; d < 2; d++) begin
        em(d, 1'b1, 25'h100, 16'h1234); em(d, 1'b1, 25'h200, 16'h5678);
        ea(d, 1'b0, 25'h100); ea(d, 1'b1, 25'h200);
      end
      strobe(0, 1'b0, 1'b1, 25'h100, 16'h1234);
      strobe(1, 1'b0, 1'b1, 25'h200, 16'h5678);
      tick();
      wait_idle();
    end

    // Tie after a port-0 grant: RR=1 picks port 1, RR=0 picks port 0.
    for (int d = 0; d < 2; d++) begin em(d, 1'b0, 25'h300, 16'h0); ea(d, 1'b0, 25'h300); end
    strobe(0, 1'b1, 1'b0, 25'h300, 16'h0);
    tick();
    wait_idle();
    m_busy = 1'b1;
    em(0, 1'b0, 25'h500, 16'h0); em(0, 1'b0, 25'h400, 16'h0);
    ea(0, 1'b1, 25'h500); ea(0, 1'b0, 25'h400);
    em(1, 1'b0, 25'h400, 16'h0); em(1, 1'b0, 25'h500, 16'h0);
    ea(1, 1'b0, 25'h400); ea(1, 1'b1, 25'h500);
    strobe(0, 1'b1, 1'b0, 25'h400, 16'h0);
    strobe(1, 1'b1, 1'b0, 25'h500, 16'h0);
    tick();
    repeat (3) @(negedge clk);
    m_busy = 1'b0;
    wait_idle();

    // m_busy held high: request waits, issues right after m_busy falls.
    m_busy = 1'b1;
    for (int d = 0; d < 2; d++) begin em(d, 1'b0, 25'h600, 16'h0); ea(d, 1'b1, 25'h600); end
    strobe(1, 1'b1, 1'b0, 25'h600, 16'h0);
    tick();
    nb0 = nstrobe[0]; nb1 = nstrobe[1];
    repeat (20) @(negedge clk);
    chk("t3_no_strobe0", 32'(nstrobe[0] - nb0), 32'd0);
    chk("t3_no_strobe1", 32'(nstrobe[1] - nb1), 32'd0);
    chk("t3_c1_busy", 32'(c1_busy[0]), 32'd1);
    m_busy = 1'b0;
    @(negedge clk);
    chk("t3_issue0", 32'(m_rd[0]), 32'd1);
    chk("t3_issue1", 32'(m_rd[1]), 32'd1);
    wait_idle();

    // rd+wr together becomes a write; a strobe while busy is dropped.
    for (int d = 0; d < 2; d++) begin em(d, 1'b1, 25'h700, 16'h9ABC); ea(d, 1'b0, 25'h700); end
    nb0 = nstrobe[0];
    strobe(0, 1'b1, 1'b1, 25'h700, 16'h9ABC);
    tick();
    @(negedge clk);
    chk("t4_busy", 32'(c0_busy[0]), 32'd1);
    strobe(0, 1'b1, 1'b0, 25'h800, 16'h0);
    tick();
    wait_idle();
    chk("t4_one_strobe", 32'(nstrobe[0] - nb0), 32'd1);

    // New strobe in the same cycle as c0_ack is accepted.
    for (int d = 0; d < 2; d++) begin
      em(d, 1'b0, 25'h900, 16'h0); ea(d, 1'b0, 25'h900);
      em(d, 1'b0, 25'hA00, 16'h0); ea(d, 1'b0, 25'hA00);
    end
    strobe(0, 1'b1, 1'b0, 25'h900, 16'h0);
    tick();
    wait_c0_ack("t5_ack_seen");
    strobe(0, 1'b1, 1'b0, 25'hA00, 16'h0);
    tick();
    wait_idle();

    // Reset while waiting on port 1: no ack, late m_ack ignored.
    for (int d = 0; d < 2; d++) em(d, 1'b0, 25'hB00, 16'h0);
    strobe(1, 1'b1, 1'b0, 25'hB00, 16'h0);
    tick();
    for (int i = 0; i < 20 && m_rd[0] !== 1'b1; i++) @(negedge clk);
    chk("t6_m_rd_seen", 32'(m_rd[0]), 32'd1);
    repeat (2) @(negedge clk);
    na0 = nack[0];
    do_reset();
    repeat (8) @(negedge clk);
    chk("t6_no_ack", 32'(nack[0] - na0), 32'd0);
    chk("t6_c1_busy", 32'(c1_busy[0]), 32'd0);
    chk("t6_c1_dout", 32'(c1_dout[0]), 32'd0);
    for (int d = 0; d < 2; d++) begin em(d, 1'b0, 25'hC00, 16'h0); ea(d, 1'b0, 25'hC00); end
    strobe(0, 1'b1, 1'b0, 25'hC00, 16'h0);
    tick();
    wait_idle();

    chk("queues_drained", 32'(qm[0].size() + qm[1].size() + qa[0].size() + qa[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
